serial_add_ctrl: RTL and testbench

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

---
 rtl/serial_add_pkg.sv | 5 +
 rtl/serial_add_ctrl_full_adder.sv | 11 +
 rtl/serial_add_ctrl.sv | 104 ++++++++++
 tb/tb_serial_add_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// serial_add_pkg: state encoding and default operand width for the serial adder controller
package serial_add_pkg;
  localparam int WIDTH_DEF = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/serial_add_ctrl_full_adder.sv
// full_adder: one-bit full adder shared by both requesters
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic c_out,
  output logic s_out
);
  assign s_out = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: two-requester round-robin controller around a bit-serial adder
module serial_add_ctrl
  import serial_add_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic             cin0,
  input  logic             cin1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH) + 1;
  state_t state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0] gnt_q, gnt_d;
  logic c_q, c_d, cout_q, cout_d, last_q, last_d, own_q, own_d, id_q, id_d;
  logic fa_s, fa_c, win;
  full_adder u_fa (.a(a_q[0]), .b(b_q[0]), .c_in(c_q), .c_out(fa_c), .s_out(fa_s));
  // a_q doubles as the result shift register: sum bits enter at the top as operand bits leave the bottom
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    last_d  = last_q;
    own_d   = own_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    id_d    = id_q;
    win     = req[1] & (~req[0] | ~last_q);
    case (state_q)
      IDLE: if (|req) begin
        state_d = RUN;
        a_d     = win ? a1 : a0;
        b_d     = win ? b1 : b0;
        c_d     = win ? cin1 : cin0;
        gnt_d   = win ? 2'b10 : 2'b01;
        last_d  = win;
        own_d   = win;
        cnt_d   = '0;
      end
      RUN: begin
        a_d   = {fa_s, a_q[WIDTH-1:1]};
        b_d   = b_q >> 1;
        c_d   = fa_c;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          sum_d   = a_d;
          cout_d  = fa_c;
          id_d    = own_q;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      last_q  <= 1'b1;
      own_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      id_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      own_q   <= own_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      id_q    <= id_d;
    end
  end
  assign gnt     = gnt_q;
  assign busy    = state_q != IDLE;
  assign done    = state_q == DONE;
  assign done_id = id_q;
  assign sum     = sum_q;
  assign cout    = cout_q;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed checks of arbitration, serial sums, timing and reset abort
module tb_serial_add_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] req, gnt;
  logic [7:0] a0, b0, a1, b1, sum;
  logic cin0, cin1, busy, done, done_id, cout;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  serial_add_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .cin0(cin0), .cin1(cin1), .gnt(gnt), .busy(busy), .done(done),
    .done_id(done_id), .sum(sum), .cout(cout)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    rst_n = 1'b0; req = 2'b00; cin0 = 1'b0; cin1 = 1'b0;
    a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;
    cyc(2);
    chk("reset_outputs", {gnt, busy, done, done_id, cout, sum}, 0);
    // single request from requester 0: 0xFF + 0x01
    rst_n = 1'b1; req = 2'b01; a0 = 8'hFF; b0 = 8'h01;
    cyc(1);
    chk("t1_gnt", gnt, 2'b01);
    chk("t1_busy", busy, 1);
    req = 2'b00;
    cyc(7);
    chk("t1_done_early", done, 0);
    cyc(1);
    chk("t1_done", {done, done_id, cout, sum}, {1'b1, 1'b0, 1'b1, 8'h00});
    cyc(1);
    chk("t1_after", {done, busy, cout, sum}, {1'b0, 1'b0, 1'b1, 8'h00});
    // tie from reset release: requester 0 first, then 1 ten cycles later
    rst_n = 1'b0;
    #1 chk("t2_reset", {gnt, busy, done, done_id, cout, sum}, 0);
    a0 = 8'h12; b0 = 8'h34; a1 = 8'hF0; b1 = 8'h0F; cin1 = 1'b1; req = 2'b11;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    chk("t2_gnt0", gnt, 2'b01);
    req = 2'b10;
    cyc(8);
    chk("t2_res0", {done, done_id, cout, sum}, {1'b1, 1'b0, 1'b0, 8'h46});
    cyc(1);
    chk("t2_gap", gnt, 2'b00);
    cyc(1);
    chk("t2_gnt1_spacing", gnt, 2'b10);
    req = 2'b00;
    cyc(8);
    chk("t2_res1", {done, done_id, cout, sum}, {1'b1, 1'b1, 1'b1, 8'h00});
    cyc(1);
    chk("t2_idle", {busy, done, done_id, sum}, {1'b0, 1'b0, 1'b1, 8'h00});
    // requester 1 alone: 0xAA + 0x55
    req = 2'b10; a1 = 8'hAA; b1 = 8'h55; cin1 = 1'b0;
    cyc(1);
    chk("t3_gnt", gnt, 2'b10);
    req = 2'b00;
    cyc(8);
    chk("t3_res", {done, done_id, cout, sum}, {1'b1, 1'b1, 1'b0, 8'hFF});
    cyc(1);
    // tie after requester 1 won goes to 0; operand change during RUN is ignored
    req = 2'b11; a0 = 8'h80; b0 = 8'h80; cin0 = 1'b0;
    cyc(1);
    chk("t4_tie_gnt", gnt, 2'b01);
    req = 2'b00;
    cyc(2);
    a0 = 8'h00; b0 = 8'h00; cin0 = 1'b1;
    cyc(6);
    chk("t4_res", {done, done_id, cout, sum}, {1'b1, 1'b0, 1'b1, 8'h00});
    cyc(1);
    // requester 0 raises then withdraws while busy
    req = 2'b10; a1 = 8'h01; b1 = 8'h01; cin1 = 1'b0;
    cyc(1);
    chk("t5_gnt", gnt, 2'b10);
    req = 2'b00;
    for (int i = 1; i <= 7; i++) begin
      cyc(1);
      req = (i >= 2 && i <= 4) ? 2'b01 : 2'b00;
      chk("t5_no_gnt", {gnt, done}, 0);
    end
    cyc(1);
    chk("t5_res", {done, done_id, cout, sum}, {1'b1, 1'b1, 1'b0, 8'h02});
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("t5_quiet", {gnt, done, busy}, 0);
    end
    // reset mid-RUN aborts, then requester 0 restarts cleanly
    req = 2'b01; a0 = 8'h0F; b0 = 8'h01; cin0 = 1'b0;
    cyc(1);
    chk("t6_gnt", gnt, 2'b01);
    cyc(3);
    rst_n = 1'b0;
    #1 chk("t6_abort", {gnt, busy, done, done_id, cout, sum}, 0);
    cyc(2);
    chk("t6_held", {gnt, busy, done}, 0);
    rst_n = 1'b1;
    cyc(1);
    chk("t6_regnt", gnt, 2'b01);
    req = 2'b00;
    cyc(7);
    chk("t6_no_early_done", done, 0);
    cyc(1);
    chk("t6_res", {done, done_id, cout, sum}, {1'b1, 1'b0, 1'b0, 8'h10});
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
